// File: rtl/serial_out.sv
`default_nettype none
// ============================================================================
// Module      : serial_out
// Description : Buffered 8N1 serial transmitter with hardware flow control.
//               Bytes written through a strobe interface are queued in a
//               power-of-two FIFO and shifted out LSB first on tx. A new
//               frame is only started while the remote's cts_n is low, as
//               seen through a two-flop synchronizer. A frame that has
//               already started always runs to completion.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLK_FREQUENCY_HZ : clk frequency in Hz
//   SERIAL_BPS       : line bit rate; bit period = CLK_FREQUENCY_HZ/SERIAL_BPS
//   FIFO_DEPTH       : transmit buffer depth in bytes (power of two, >= 2)
// Ports
//   clk            in   single clock for all logic
//   rst_n          in   asynchronous active-low reset
//   data[7:0]      in   byte to transmit
//   data_available in   one-cycle write strobe for data
//   ready          out  FIFO can accept a byte this cycle
//   cts_n          in   remote clear-to-send, low = remote may receive
//   tx             out  registered serial line, idle high
//   busy           out  frame on the line or FIFO non-empty
//   overflow       out  one-cycle pulse when a write is dropped
// ============================================================================
module serial_out #(
  parameter int CLK_FREQUENCY_HZ = 25_000_000,
  parameter int SERIAL_BPS       = 115_200,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       data_available,
  output logic       ready,
  input  logic       cts_n,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int c_BIT_CYCLES = CLK_FREQUENCY_HZ / SERIAL_BPS;
  // A one-clock bit period still needs a one-bit counter to exist.
  localparam int c_CNT_W      = (c_BIT_CYCLES > 1) ? $clog2(c_BIT_CYCLES) : 1;
  localparam int c_AW         = $clog2(FIFO_DEPTH);
  localparam int c_PW         = c_AW + 1;

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_BIT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_PW-1:0]    c_PTR_ONE  = c_PW'(1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_START = 2'd1;
  localparam logic [1:0] c_ST_DATA  = 2'd2;
  localparam logic [1:0] c_ST_STOP  = 2'd3;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]    r_wr_ptr;
  logic [c_PW-1:0]    r_rd_ptr;

  logic               r_cts_meta;
  logic               r_cts_sync;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;

  logic [c_CNT_W-1:0] r_baud_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_tx;

  logic               w_empty;
  logic               w_full;
  logic               w_wr_en;
  logic [7:0]         w_head;
  logic               w_bit_done;
  logic               w_start_ok;
  logic               w_load;
  logic               w_shift;
  logic               w_tx_next;

  // --------------------------------------------------------------------------
  // Clear-to-send synchronizer. Both stages reset to the "not clear" level so
  // that nothing can be launched until a real low has crossed both flops.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cts_meta <= 1'b1;
      r_cts_sync <= 1'b1;
    end else begin
      r_cts_meta <= cts_n;
      r_cts_sync <= r_cts_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Transmit FIFO. Pointers carry one extra wrap bit so full and empty can be
  // told apart when the index bits match.
  // --------------------------------------------------------------------------
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                   (r_wr_ptr[c_AW]     != r_rd_ptr[c_AW]);

  // Full is judged before any same-cycle pop, so a write into a full buffer
  // is dropped even if a byte leaves on the same edge.
  assign w_wr_en = data_available && !w_full;
  assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame state machine
  // --------------------------------------------------------------------------
  assign w_bit_done = (r_baud_cnt == c_CNT_LAST);
  assign w_start_ok = !w_empty && !r_cts_sync;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. The end of a stop bit makes the same launch decision as
  // IDLE would, so queued bytes follow each other without an idle clock.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_start_ok) begin
          w_state_next = c_ST_START;
        end
      end
      c_ST_START: begin
        if (w_bit_done) begin
          w_state_next = c_ST_DATA;
        end
      end
      c_ST_DATA: begin
        if (w_bit_done && (r_bit_idx == 3'd7)) begin
          w_state_next = c_ST_STOP;
        end
      end
      c_ST_STOP: begin
        if (w_bit_done) begin
          w_state_next = w_start_ok ? c_ST_START : c_ST_IDLE;
        end
      end
      default: begin
        w_state_next = c_ST_IDLE;
      end
    endcase
  end

  // Output / control decode from the current state
  always_comb begin
    w_tx_next = 1'b1;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        w_load = w_start_ok;
      end
      c_ST_START: begin
        w_tx_next = 1'b0;
      end
      c_ST_DATA: begin
        w_tx_next = r_shift[0];
        w_shift   = w_bit_done;
      end
      c_ST_STOP: begin
        w_load = w_bit_done && w_start_ok;
      end
      default: begin
        w_tx_next = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: baud counter, bit index, shift register and the line flop.
  // tx is one clock behind the state, which keeps every input two flops away
  // from the pin and gives the write-to-start-bit latency of two edges.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx <= w_tx_next;

      // Counter parks at zero in IDLE, so a launch always starts a full bit.
      if ((r_state == c_ST_IDLE) || w_bit_done) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
      end

      if (w_load) begin
        r_shift <= w_head;
      end else if (w_shift) begin
        r_shift <= {1'b0, r_shift[7:1]};
      end

      if (r_state != c_ST_DATA) begin
        r_bit_idx <= '0;
      end else if (w_bit_done) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign tx       = r_tx;
  assign ready    = !w_full;
  assign overflow = data_available && w_full;
  assign busy     = (r_state != c_ST_IDLE) || !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_serial_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_out
// Description : Self-checking bench for serial_out. A queue of bytes the
//               line is expected to carry, plus an occupancy count, model the
//               transmitter; a line decoder checks every bit level for its
//               exact duration and value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_out;

  localparam int CLK_HZ = 2_500_000;
  localparam int BPS    = 115_200;
  localparam int DEPTH  = 16;
  localparam int BIT    = CLK_HZ / BPS;  // 21 clocks, truncated

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       data_available;
  logic       ready;
  logic       cts_n;
  logic       tx;
  logic       busy;
  logic       overflow;

  always #5 clk = ~clk;

  serial_out #(
    .CLK_FREQUENCY_HZ(CLK_HZ),
    .SERIAL_BPS      (BPS),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data          (data),
    .data_available(data_available),
    .ready         (ready),
    .cts_n         (cts_n),
    .tx            (tx),
    .busy          (busy),
    .overflow      (overflow)
  );

  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] q_exp[$];  // bytes expected on the line, in order
  int         lvl     = 0;  // bytes accepted but not yet started

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called just after a rising edge; the write is captured on the next edge.
  task automatic wr(input logic [7:0] b);
    logic exp_full;
    exp_full       = (lvl >= DEPTH);
    data           = b;
    data_available = 1'b1;
    @(negedge clk);
    chk("ready_at_write", ready, !exp_full);
    chk("overflow_at_write", overflow, exp_full);
    @(posedge clk);
    #1;
    data_available = 1'b0;
    if (!exp_full) begin
      q_exp.push_back(b);
      lvl++;
    end
  endtask

  // Waits for a start bit and checks all ten levels of the frame against the
  // next queued byte. gap = idle samples seen before the start bit.
  // raise_bit >= 0 lifts cts_n at the start of that level (4 = data bit 3).
  task automatic recv(output int gap, input int raise_bit);
    logic [7:0] b;
    logic       exp_bit;
    int         hits;
    gap = 0;
    @(negedge clk);
    while ((tx !== 1'b0) && (gap < 40 * BIT)) begin
      gap++;
      @(negedge clk);
    end
    if (tx !== 1'b0) begin
      chk("frame_start_timeout", tx, 0);
      gap = -1;
      return;
    end
    if (q_exp.size() == 0) begin
      chk("frame_without_queued_byte", q_exp.size(), 1);
      return;
    end
    b = q_exp.pop_front();
    if (lvl > 0) lvl--;
    for (int w = 0; w < 10; w++) begin
      if (w == 0) exp_bit = 1'b0;
      else if (w == 9) exp_bit = 1'b1;
      else exp_bit = b[w-1];
      if (w == raise_bit) cts_n = 1'b1;
      hits = 0;
      for (int c = 0; c < BIT; c++) begin
        if (!((w == 0) && (c == 0))) @(negedge clk);
        if (tx === exp_bit) hits++;
      end
      chk($sformatf("frame_%02h_level%0d", b, w), hits, BIT);
    end
  endtask

  initial begin
    int         gap;
    int         bad;
    int         n_rand;
    logic [7:0] rb;

    rst_n          = 1'b0;
    data           = 8'h00;
    data_available = 1'b0;
    cts_n          = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_overflow", overflow, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Single 0x55 frame with latency check
    wr(8'h55);
    @(negedge clk);
    chk("latency_after_edge_n", tx, 1);
    chk("busy_after_write", busy, 1);
    @(negedge clk);
    chk("latency_after_edge_n1", tx, 1);
    recv(gap, -1);
    chk("latency_start_at_edge_n2", gap, 0);
    @(negedge clk);
    chk("idle_tx_after_55", tx, 1);
    chk("busy_after_55", busy, 0);

    // Back-to-back frames 0xA3, 0x0F
    @(posedge clk); #1;
    wr(8'hA3);
    wr(8'h0F);
    recv(gap, -1);
    recv(gap, -1);
    chk("back_to_back_gap", gap, 0);
    @(negedge clk);
    chk("busy_after_pair", busy, 0);

    // Fill with cts_n high: 16 accepted, 17th overflows, line stays idle
    @(posedge clk); #1;
    cts_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    lvl = 0;
    for (int i = 0; i <= DEPTH; i++) wr(8'(i));
    @(negedge clk);
    chk("ready_when_full", ready, 0);
    chk("overflow_single_pulse", overflow, 0);
    bad = 0;
    for (int k = 0; k < 3 * BIT; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    chk("tx_idle_while_cts_high", bad, 0);
    cts_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) recv(gap, -1);
    bad = 0;
    for (int k = 0; k < 4 * BIT; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    chk("dropped_byte_never_sent", bad, 0);
    chk("busy_after_drain", busy, 0);

    // cts_n raised mid-frame: frame completes, queued byte waits
    @(posedge clk); #1;
    wr(8'h80);
    wr(8'h3C);
    recv(gap, 4);
    bad = 0;
    for (int k = 0; k < 3 * BIT; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    chk("second_byte_held_by_cts", bad, 0);
    chk("busy_while_held", busy, 1);
    cts_n = 1'b0;
    recv(gap, -1);
    @(negedge clk);
    chk("busy_after_cts_resume", busy, 0);

    // Reset during DATA of 0xFF with 3 bytes queued
    @(posedge clk); #1;
    wr(8'hFF);
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    for (int k = 0; (k < 40 * BIT) && (tx !== 1'b0); k++) @(negedge clk);
    chk("ff_frame_started", tx, 0);
    repeat (2 * BIT) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_tx", tx, 1);
    chk("midframe_reset_ready", ready, 1);
    chk("midframe_reset_busy", busy, 0);
    q_exp.delete();
    lvl = 0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    cts_n = 1'b0;
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 15 * BIT; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    chk("nothing_sent_after_reset", bad, 0);
    chk("busy_after_reset", busy, 0);

    // Randomized bytes queued with cts_n high, then drained
    @(posedge clk); #1;
    cts_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_rand = $urandom_range(4, 20);
    for (int i = 0; i < n_rand; i++) begin
      rb = 8'($urandom);
      wr(rb);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    chk("rand_tx_idle", tx, 1);
    chk("rand_busy_queued", busy, 1);
    cts_n = 1'b0;
    while (q_exp.size() > 0) begin
      recv(gap, -1);
      if (gap < 0) break;
    end
    @(negedge clk);
    chk("rand_busy_after_drain", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_out.md
SERIAL_OUT -- requirements
Module: serial_out

Interface
REQ-001 SHALL have parameter CLK_FREQUENCY_HZ, default 25_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter SERIAL_BPS, default 115_200, meaning the line bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16 (power of two, >=2), meaning the transmit buffer depth in bytes.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1, the reset; asynchronous assert, active-low.
REQ-006 SHALL have port data, input, 8, the byte to transmit.
REQ-007 SHALL have port data_available, input, 1, a one-cycle write strobe for data.
REQ-008 SHALL have port ready, output, 1, high when the FIFO can accept a byte.
REQ-009 SHALL have port cts_n, input, 1, the remote clear-to-send; low means the remote may receive.
REQ-010 SHALL have port tx, output, 1, the serial line, idle high.
REQ-011 SHALL have port busy, output, 1, high while a frame is on the line or the FIFO is non-empty.
REQ-012 SHALL have port overflow, output, 1, a one-cycle pulse when a write is dropped.

Function
REQ-013 Bit period SHALL be BIT_CYCLES = CLK_FREQUENCY_HZ / SERIAL_BPS, using integer truncation (217 at the defaults); the baud counter SHALL be $clog2(BIT_CYCLES) bits wide.
REQ-014 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each lasting exactly BIT_CYCLES clocks.
REQ-015 A write SHALL be accepted when data_available=1 and ready=1, storing data at the FIFO tail on that clock edge.
REQ-016 ready SHALL equal !full, where full is evaluated before that cycle's pop; a write when full is rejected even if a pop occurs in the same cycle.
REQ-017 A write with data_available=1 and ready=0 SHALL be discarded, and overflow SHALL pulse high for exactly that cycle.
REQ-018 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide: empty when the pointers are equal; full when the low bits are equal and the MSBs differ; pointers wrap naturally.
REQ-019 The state machine SHALL have the states IDLE, START, DATA, STOP.
REQ-020 IDLE -> START when the FIFO is non-empty and cts_n=0 (sampled through a 2-flop synchronizer); on that transition the head byte SHALL be popped into a shift register and the baud counter cleared.
REQ-021 START: tx=0 for BIT_CYCLES, then -> DATA with the bit index at 0.
REQ-022 DATA: tx=shift[0]; after each BIT_CYCLES the register SHALL shift right and the index increment; after bit 7 -> STOP.
REQ-023 STOP: tx=1 for BIT_CYCLES, then -> IDLE.
REQ-024 cts_n SHALL be honoured only in IDLE; a frame in progress always completes.
REQ-025 Back-to-back frames SHALL follow with no idle gap: the IDLE->START decision is made on the cycle STOP ends, so the next start bit begins the following cycle.
REQ-026 Latency: with the FIFO empty, IDLE, and cts_n synchronized low, a write at edge N SHALL drive tx=0 from edge N+2.
REQ-027 tx SHALL be registered, with no combinational path from any input to tx.
REQ-028 busy SHALL be (state!=IDLE) || !empty.

Reset
REQ-029 While rst_n=0: tx=1, ready=1, busy=0, overflow=0, state=IDLE, FIFO pointers=0, baud counter=0, bit index=0, synchronizer flops=1 (not clear).
REQ-030 Reset asserted mid-frame SHALL force tx=1 asynchronously and discard the frame and all FIFO contents.
REQ-031 After rst_n deasserts, no frame SHALL start until cts_n has been low through both synchronizer stages.

Verification
REQ-032 Defaults, cts_n=0, write 0x55 -> tx pattern 0,1,0,1,0,1,0,1,0,1, each level held exactly 217 clocks; then busy=0.
REQ-033 cts_n=0, write 0xA3 then 0x0F on consecutive cycles -> two frames, with the second start bit beginning the clock after the first stop bit ends (stop held exactly 217 clocks).
REQ-034 cts_n=1, write 17 bytes 0x00..0x10 -> ready=0 after 16, overflow pulses once on the 17th, tx stays 1; then cts_n=0 -> 0x00..0x0F are sent in order and 0x10 never appears.
REQ-035 Mid-frame, 0x80 in DATA bit 3, raise cts_n=1 -> the frame completes; a queued second byte does not start until cts_n returns to 0.
REQ-036 Assert rst_n=0 during DATA of 0xFF with 3 bytes queued -> tx=1 immediately, ready=1, busy=0; after release with cts_n=0, nothing is transmitted.
